// File: rtl/sram_rw_arbiter_pkg.sv
// Shared types for the SRAM RW0 arbiter: controller state, response entry and lane geometry.
package sram_rw_arbiter_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    // Response entries carry up to RSP_DATA_W bits of read data; DATA_W must not exceed it.
    localparam int RSP_DATA_W = 64;

    typedef struct packed {
        logic                  id;
        logic [RSP_DATA_W-1:0] data;
    } rsp_entry_t;

    function automatic int lane_w(input int data_w, input int mask_w);
        return data_w / mask_w;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo2.sv
// Two-entry valid/ready response FIFO; a pop and a push may share a cycle even when full.
module sram_rsp_fifo2
    import sram_rw_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       i_push,
    input  rsp_entry_t i_push_data,
    output logic       o_valid,
    input  logic       i_ready,
    output rsp_entry_t o_data,
    output logic [1:0] o_count
);

    rsp_entry_t r_slot [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_pop;

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_slot[r_rd_ptr];
    assign o_count = r_count;
    assign w_pop   = o_valid && i_ready;

    // When full, the write slot is the slot being popped, so push+pop never clobbers live data.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_slot[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(i_push) - 2'(w_pop);
        end
    end

endmodule

// File: rtl/sram_rw_arbiter.sv
// Shares one single-port RW SRAM between two requesters: zero-fill sweep, round-robin grant,
// read admission against a 2-entry response buffer.
module sram_rw_arbiter
    import sram_rw_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 9,
    parameter int DATA_W        = 64,
    parameter int MASK_W        = 8,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_wmode,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*MASK_W-1:0]   req_wmask,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  init_done,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_en,
    output logic                  mem_wmode,
    output logic [MASK_W-1:0]     mem_wmask,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    arb_state_e        r_state;
    logic [ADDR_W-1:0] r_init_cnt;
    logic              r_init_done;
    logic              r_last_grant;
    logic              r_inflight;
    logic              r_inflight_id;
    logic [ADDR_W-1:0] r_hold_addr;
    logic [MASK_W-1:0] r_hold_wmask;
    logic [DATA_W-1:0] r_hold_wdata;

    logic [1:0]        w_fifo_count;
    logic              w_pop;
    logic [2:0]        w_load;
    logic              w_read_ok;
    logic              w_run;
    logic [1:0]        w_elig;
    logic              w_grant_any;
    logic              w_grant_id;
    logic              w_win_wmode;
    logic [ADDR_W-1:0] w_win_addr;
    logic [MASK_W-1:0] w_win_wmask;
    logic [DATA_W-1:0] w_win_wdata;
    rsp_entry_t        w_push_entry;
    rsp_entry_t        w_head;

    // Reads already in the FIFO or in the SRAM pipe, less the one leaving this cycle.
    assign w_pop     = rsp_valid && rsp_ready;
    assign w_load    = 3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_read_ok = (w_load < 3'd2);
    assign w_run     = (r_state == ST_RUN) && !reset;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign w_elig[gi]    = req_valid[gi] && (req_wmode[gi] || w_read_ok);
            assign req_ready[gi] = w_grant_any && (w_grant_id == 1'(gi));
        end
    endgenerate

    assign w_grant_any = w_run && (|w_elig);
    assign w_grant_id  = (&w_elig) ? ~r_last_grant : w_elig[1];

    assign w_win_wmode = w_grant_id ? req_wmode[1] : req_wmode[0];
    assign w_win_addr  = w_grant_id ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
    assign w_win_wmask = w_grant_id ? req_wmask[2*MASK_W-1:MASK_W] : req_wmask[MASK_W-1:0];
    assign w_win_wdata = w_grant_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

    always_comb begin
        mem_en    = 1'b0;
        mem_wmode = 1'b0;
        mem_addr  = r_hold_addr;
        mem_wmask = r_hold_wmask;
        mem_wdata = r_hold_wdata;
        if (!reset && r_state == ST_INIT) begin
            mem_en    = 1'b1;
            mem_wmode = 1'b1;
            mem_addr  = r_init_cnt;
            mem_wmask = '1;
            mem_wdata = '0;
        end else if (w_grant_any) begin
            mem_en    = 1'b1;
            mem_wmode = w_win_wmode;
            mem_addr  = w_win_addr;
            mem_wmask = w_win_wmask;
            mem_wdata = w_win_wdata;
        end
    end

    // Idle cycles replay the previous address/mask/data so the macro pins do not toggle.
    always_ff @(posedge clock) begin
        r_hold_addr  <= mem_addr;
        r_hold_wmask <= mem_wmask;
        r_hold_wdata <= mem_wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            r_init_cnt    <= '0;
            r_init_done   <= 1'b0;
            r_last_grant  <= 1'b1;
            r_inflight    <= 1'b0;
            r_inflight_id <= 1'b0;
        end else begin
            r_inflight    <= w_grant_any && !w_win_wmode;
            r_inflight_id <= w_grant_id;
            if (w_grant_any) begin
                r_last_grant <= w_grant_id;
            end
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == LAST_ADDR) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    r_init_done <= 1'b1;
                end
            endcase
        end
    end

    assign w_push_entry.id   = r_inflight_id;
    assign w_push_entry.data = RSP_DATA_W'(mem_rdata);

    sram_rsp_fifo2 u_fifo (
        .clk         (clock),
        .srst        (reset),
        .i_push      (r_inflight),
        .i_push_data (w_push_entry),
        .o_valid     (rsp_valid),
        .i_ready     (rsp_ready),
        .o_data      (w_head),
        .o_count     (w_fifo_count)
    );

    assign rsp_id    = w_head.id;
    assign rsp_data  = DATA_W'(w_head.data);
    assign init_done = r_init_done;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Bench for sram_rw_arbiter: SRAM macro model, transaction-level reference model, scenario tasks.
`timescale 1ns/1ps
module tb_sram_rw_arbiter;
    import sram_rw_arbiter_pkg::*;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;
    localparam int MASK_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int LW     = lane_w(DATA_W, MASK_W);

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [1:0]          req_valid = '0;
    logic [1:0]          req_ready;
    logic [1:0]          req_wmode = '0;
    logic [2*ADDR_W-1:0] req_addr = '0;
    logic [2*MASK_W-1:0] req_wmask = '0;
    logic [2*DATA_W-1:0] req_wdata = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic                rsp_id;
    logic [DATA_W-1:0]   rsp_data;
    logic                init_done;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_en;
    logic                mem_wmode;
    logic [MASK_W-1:0]   mem_wmask;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sram_rw_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .INIT_ON_RESET(1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wmode(req_wmode),
        .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .init_done(init_done),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_wmode(mem_wmode),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // SRAM macro: seeded with garbage so the zero-fill sweep is observable.
    logic [DATA_W-1:0] sram [DEPTH];
    bit seeded = 1'b0;
    always @(posedge clock) begin
        if (!seeded) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= {$urandom, $urandom};
            seeded <= 1'b1;
        end else if (mem_en) begin
            if (mem_wmode) begin
                for (int l = 0; l < MASK_W; l++)
                    if (mem_wmask[l]) sram[mem_addr][l*LW +: LW] <= mem_wdata[l*LW +: LW];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    // Reference model: memory image, outstanding read list, last winner.
    typedef struct {
        logic              id;
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    exp_t              exp_q [$];
    exp_t              m_e;
    int                m_cyc = 0;
    int                m_init = 0;
    int                m_last = 1;
    int                m_nout, m_g;
    bit                m_rv, m_pop, m_rok, m_el0, m_el1;
    logic [1:0]        m_exp_ready;
    logic [ADDR_W-1:0] m_a;
    logic [MASK_W-1:0] m_m;
    logic [DATA_W-1:0] m_d;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                 input logic [DATA_W-1:0] new_w,
                                                 input logic [MASK_W-1:0] m);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int l = 0; l < MASK_W; l++) if (m[l]) r[l*LW +: LW] = new_w[l*LW +: LW];
        return r;
    endfunction

    always @(negedge clock) begin
        m_cyc++;
        if (reset) begin
            checks++;
            if (mem_en !== 1'b0 || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL reset_outputs: mem_en=%b req_ready=%b, required 0/00", mem_en, req_ready);
            end
            exp_q.delete();
            m_last = 1;
            m_init = 0;
        end else if (m_init < DEPTH) begin
            checks++;
            if (init_done !== 1'b0 || req_ready !== 2'b00 || rsp_valid !== 1'b0 || mem_en !== 1'b1 ||
                mem_wmode !== 1'b1 || mem_addr !== ADDR_W'(m_init) || mem_wmask !== '1 || mem_wdata !== '0) begin
                errors++;
                $display("FAIL init_sweep: done=%b rdy=%b en=%b wm=%b addr=%0d mask=%h wdata=%h, required sweep write addr %0d",
                         init_done, req_ready, mem_en, mem_wmode, mem_addr, mem_wmask, mem_wdata, m_init);
            end
            m_init++;
            if (m_init == DEPTH) for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end else begin
            m_nout = exp_q.size();
            m_rv   = (m_nout > 0) && (exp_q[0].cyc <= m_cyc - 2);
            m_pop  = m_rv && rsp_ready;
            checks++;
            if (init_done !== 1'b1 || rsp_valid !== m_rv) begin
                errors++;
                $display("FAIL rsp_valid: init_done=%b rsp_valid=%b, required 1/%b", init_done, rsp_valid, m_rv);
            end
            if (m_pop) begin
                m_e = exp_q.pop_front();
                checks++;
                if (rsp_id !== m_e.id || rsp_data !== m_e.data) begin
                    errors++;
                    $display("FAIL rsp_data: id=%b data=%h, required id=%b data=%h", rsp_id, rsp_data, m_e.id, m_e.data);
                end
            end
            m_rok = (m_nout - (m_pop ? 1 : 0)) < 2;
            m_el0 = req_valid[0] && (req_wmode[0] || m_rok);
            m_el1 = req_valid[1] && (req_wmode[1] || m_rok);
            if (m_el0 && m_el1) m_g = (m_last == 0) ? 1 : 0;
            else if (m_el0)     m_g = 0;
            else if (m_el1)     m_g = 1;
            else                m_g = -1;
            m_exp_ready = (m_g < 0) ? 2'b00 : (m_g == 0 ? 2'b01 : 2'b10);
            checks++;
            if (req_ready !== m_exp_ready) begin
                errors++;
                $display("FAIL grant: req_ready=%b, required %b (valid=%b wmode=%b outstanding=%0d)",
                         req_ready, m_exp_ready, req_valid, req_wmode, m_nout);
            end
            if (m_g >= 0) begin
                m_a = req_addr[m_g*ADDR_W +: ADDR_W];
                m_m = req_wmask[m_g*MASK_W +: MASK_W];
                m_d = req_wdata[m_g*DATA_W +: DATA_W];
                checks++;
                if (mem_en !== 1'b1 || mem_wmode !== req_wmode[m_g] || mem_addr !== m_a ||
                    (req_wmode[m_g] && (mem_wmask !== m_m || mem_wdata !== m_d))) begin
                    errors++;
                    $display("FAIL mem_port: en=%b wm=%b addr=%0d mask=%h data=%h, required requester %0d fields",
                             mem_en, mem_wmode, mem_addr, mem_wmask, mem_wdata, m_g);
                end
                m_last = m_g;
                if (req_wmode[m_g]) ref_mem[m_a] = merge(ref_mem[m_a], m_d, m_m);
                else exp_q.push_back('{id: (m_g == 1), data: ref_mem[m_a], cyc: m_cyc});
            end else begin
                checks++;
                if (mem_en !== 1'b0) begin
                    errors++;
                    $display("FAIL mem_idle: mem_en=%b, required 0", mem_en);
                end
            end
            checks++;
            if (dut.u_fifo.r_count > 2'd2) begin
                errors++;
                $display("FAIL fifo_occ: count=%0d, required <=2", dut.u_fifo.r_count);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents one request and waits (bounded) for its grant; call at posedge+1.
    task automatic issue(input int id, input logic wm, input logic [ADDR_W-1:0] a,
                         input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d, output bit acc);
        acc = 1'b0;
        req_valid[id] = 1'b1;
        req_wmode[id] = wm;
        req_addr[id*ADDR_W +: ADDR_W]  = a;
        req_wmask[id*MASK_W +: MASK_W] = m;
        req_wdata[id*DATA_W +: DATA_W] = d;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (req_ready[id]) begin
                acc = 1'b1;
                break;
            end
            step();
        end
        if (acc) step();
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        for (int k = 0; k < DEPTH + 8; k++) begin
            @(negedge clock);
            if (init_done === 1'b1) break;
            n++;
        end
        step();
    endtask

    task automatic test_reset();
        int n;
        bit acc;
        reset = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        repeat (2) step();
        @(negedge clock);
        checks++;
        if (mem_en !== 1'b0 || req_ready !== 2'b00 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: mem_en=%b req_ready=%b init_done=%b, required 0/00/0", mem_en, req_ready, init_done);
        end
        step();
        reset = 1'b0;
        wait_init(n);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL init_length: init_done low for %0d cycles, required %0d", n, DEPTH);
        end
        issue(0, 1'b0, ADDR_W'(7), '0, '0, acc);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (rsp_valid === 1'b1) break;
        end
        checks++;
        if (!acc || rsp_valid !== 1'b1 || rsp_data !== '0 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL init_read7: acc=%b valid=%b id=%b data=%h, required 1/1/0/0", acc, rsp_valid, rsp_id, rsp_data);
        end
        step();
        $display("test_reset: sweep %0d cycles, addr 7 read back", n);
    endtask

    task automatic test_masked_write();
        bit acc_w, acc_r;
        int lat;
        issue(0, 1'b1, ADDR_W'(5'h1A), 8'h0F, 64'h1122334455667788, acc_w);
        issue(0, 1'b0, ADDR_W'(5'h1A), '0, '0, acc_r);
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (rsp_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (!acc_w || !acc_r || lat != 2 || rsp_data !== 64'h0000000055667788 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL masked_rw: acc=%b%b latency=%0d id=%b data=%h, required 11/2/0/0000000055667788",
                     acc_w, acc_r, lat, rsp_id, rsp_data);
        end
        step();
        $display("test_masked_write: latency %0d data %h", lat, rsp_data);
    endtask

    task automatic test_round_robin();
        int n;
        logic [1:0] exp_r;
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        wait_init(n);
        req_wmode = 2'b11;
        req_valid = 2'b11;
        for (int k = 0; k < 12; k++) begin
            if (k == 8) req_valid = 2'b10;
            req_addr  = {ADDR_W'($urandom), ADDR_W'($urandom)};
            req_wmask = {MASK_W'($urandom), MASK_W'($urandom)};
            req_wdata = {$urandom, $urandom, $urandom, $urandom};
            exp_r = (k >= 8) ? 2'b10 : ((k % 2 == 0) ? 2'b01 : 2'b10);
            @(negedge clock);
            checks++;
            if (req_ready !== exp_r) begin
                errors++;
                $display("FAIL round_robin: cycle %0d req_ready=%b, required %b", k, req_ready, exp_r);
            end
            step();
        end
        req_valid = '0;
        $display("test_round_robin: 8 alternating grants then 4 to requester 1");
    endtask

    task automatic test_backpressure();
        int acc, acc2, pops;
        rsp_ready = 1'b0;
        req_wmode[1] = 1'b0;
        req_valid[1] = 1'b1;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            req_addr[ADDR_W +: ADDR_W] = ADDR_W'($urandom);
            @(negedge clock);
            if (req_ready[1]) acc++;
            step();
        end
        checks++;
        if (acc != 2) begin
            errors++;
            $display("FAIL bp_accept: %0d reads accepted while stalled, required 2", acc);
        end
        rsp_ready = 1'b1;
        req_addr[ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        @(negedge clock);
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL full_pop_grant: req_ready=%b, required 10", req_ready);
        end
        acc2 = int'(req_ready[1]);
        pops = int'(rsp_valid);
        step();
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            acc2 += int'(req_ready[1]);
            step();
        end
        checks++;
        if (acc2 != 1) begin
            errors++;
            $display("FAIL bp_pulse: %0d reads accepted for one pop, required 1", acc2);
        end
        req_valid[1] = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            pops += int'(rsp_valid);
            step();
        end
        checks++;
        if (pops != 3) begin
            errors++;
            $display("FAIL bp_drain: %0d responses delivered, required 3", pops);
        end
        $display("test_backpressure: accepted %0d+%0d, delivered %0d", acc, acc2, pops);
    endtask

    task automatic test_full_pop();
        rsp_ready = 1'b0;
        req_wmode[0] = 1'b0;
        req_valid[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_addr[0 +: ADDR_W] = ADDR_W'($urandom);
            step();
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_addr[0 +: ADDR_W] = ADDR_W'($urandom);
            @(negedge clock);
            checks++;
            if (req_ready !== 2'b01) begin
                errors++;
                $display("FAIL full_pop_stream: cycle %0d req_ready=%b, required 01", k, req_ready);
            end
            step();
        end
        req_valid = '0;
        repeat (4) step();
        @(negedge clock);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_drain: rsp_valid=%b, required 0", rsp_valid);
        end
        step();
        $display("test_full_pop: streamed reads through a full buffer");
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            req_valid = 2'($urandom);
            req_wmode = 2'($urandom);
            req_addr  = {ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7))};
            req_wmask = {MASK_W'($urandom), MASK_W'($urandom)};
            req_wdata = {$urandom, $urandom, $urandom, $urandom};
            rsp_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) step();
        @(negedge clock);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_drain: rsp_valid=%b, required 0", rsp_valid);
        end
        step();
        $display("test_random: 400 cycles of mixed traffic");
    endtask

    task automatic test_reset_midflight();
        bit acc;
        int seen, n;
        rsp_ready = 1'b1;
        issue(1, 1'b0, ADDR_W'(3), '0, '0, acc);
        reset = 1'b1;
        req_valid[0] = 1'b1;
        req_wmode[0] = 1'b1;
        @(negedge clock);
        checks++;
        if (!acc || mem_en !== 1'b0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL midflight_reset: acc=%b mem_en=%b req_ready=%b, required 1/0/00", acc, mem_en, req_ready);
        end
        step();
        reset = 1'b0;
        req_valid = '0;
        @(negedge clock);
        checks++;
        if (mem_en !== 1'b1 || mem_wmode !== 1'b1 || mem_addr !== '0) begin
            errors++;
            $display("FAIL sweep_restart: en=%b wm=%b addr=%0d, required 1/1/0", mem_en, mem_wmode, mem_addr);
        end
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid !== 1'b0) seen++;
            @(negedge clock);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL dropped_read: rsp_valid seen %0d cycles, required 0", seen);
        end
        step();
        wait_init(n);
        $display("test_reset_midflight: sweep restarted, stale read dropped");
    endtask

    initial begin
        test_reset();
        test_masked_write();
        test_round_robin();
        test_backpressure();
        test_full_pop();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
